regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: the ALU and the load/store unit (LSU). Each requester uses a valid/ready handshake. The LSU has fixed priority, with a starvation guard that forces an ALU grant after a bounded number of consecutive losses. The granted write is registered and driven onto the register file's wr_en/wr_reg/wr_data inputs one cycle later. Writes to x0 are accepted but suppressed.

Parameters:
- REG_W, 32, width of a register / write data.
- REG_COUNT, 32, number of architectural registers; REG_IDX_W = $clog2(REG_COUNT) is derived locally, not overridable.
- STARVE_LIMIT, 3, consecutive cycles the ALU may lose arbitration before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on posedge
- aresetn  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write request pending
- alu_ready  out  1  ALU request accepted this cycle (when alu_valid=1)
- alu_reg  in  REG_IDX_W  ALU destination register
- alu_data  in  REG_W  ALU result
- lsu_valid  in  1  LSU write request pending
- lsu_ready  out  1  LSU request accepted this cycle (when lsu_valid=1)
- lsu_reg  in  REG_IDX_W  LSU destination register
- lsu_data  in  REG_W  load data
- wr_en  out  1  register file write enable
- wr_reg  out  REG_IDX_W  register file write index
- wr_data  out  REG_W  register file write data

Behaviour:
- Clock and reset: one clock, clk. Reset aresetn is asynchronous, active-low.
- Reset values: wr_en=0, wr_reg=0, wr_data=0, starve_cnt=0. Reset is asynchronous; any accepted-but-not-yet-written transfer is discarded.
- Transfer rule: a transfer occurs when valid&&ready for that requester.
- Ready signals (combinational from the valids and starve_cnt; no combinational path from wr_* outputs):
  - force = (starve_cnt == STARVE_LIMIT)
  - lsu_ready = !(alu_valid && force)
  - alu_ready = !lsu_valid || force
- Arbitration: at most one transfer per cycle is guaranteed by the equations above. Priority is LSU, except when force=1 and alu_valid=1, in which case the ALU wins.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - cleared on an ALU transfer or when alu_valid=0
  - incremented when alu_valid=1 && alu_ready=0
- Latency: a transfer in cycle N drives wr_reg/wr_data = the winner's reg/data at the next posedge. wr_en=1 for exactly that one cycle, unless the destination is 0.
- x0 handling: a transfer with destination 0 completes the handshake and affects starve_cnt normally. wr_en=0 the next cycle; wr_reg/wr_data still update.
- No transfer in a cycle: wr_en=0 next cycle; wr_reg/wr_data hold their values.
- Same destination from both requesters on back-to-back grants: written in grant order, so the later grant's data is final. No merging or dropping.
- Back-pressure: the register file is always ready, and the arbiter never stalls on its output side.
- Requester contract: each requester holds valid, reg and data stable until its handshake completes. The arbiter does not check this.

Test Plan:
1. Reset: aresetn=0 with both valids=1 -> wr_en=0, wr_reg=0, wr_data=0 held throughout. After release, the first transfer is the LSU's.
2. Single requester: ALU only, reg=5, data=0xDEADBEEF in cycle N -> alu_ready=1 in N; wr_en=1, wr_reg=5, wr_data=0xDEADBEEF in N+1; wr_en=0 in N+2.
3. Contention with STARVE_LIMIT=3: both valid continuously with distinct regs -> grant pattern LSU,LSU,LSU,ALU repeating. Exactly one ready-with-valid per cycle. ALU waits at most 3 cycles.
4. x0 suppression: LSU reg=0, data=0x1234 -> lsu_ready=1, next cycle wr_en=0, wr_data=0x1234. A following ALU write to reg=0 also produces wr_en=0.
5. Same-register race: ALU reg=7 data=0xA and LSU reg=7 data=0xB both valid -> LSU written first (0xB), ALU next (0xA). Final register file value of x7 is 0xA.
6. Reset mid-stream: assert aresetn=0 the cycle after an accepted LSU write to reg=3 -> wr_en drops immediately (asynchronously), the reg=3 write never occurs, and starve_cnt=0 after release.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single register-file write port between the
// ALU and the LSU. The LSU normally wins. A saturating starvation counter
// forces an ALU grant once the ALU has lost STARVE_LIMIT cycles in a row.
// The granted write is registered and presented on wr_* one cycle later.
// Writes to x0 complete their handshake, but wr_en is held low for them.
module regfile_wr_arbiter #(
  parameter int REG_W        = 32,
  parameter int REG_COUNT    = 32,
  parameter int STARVE_LIMIT = 3    // legal range 1..15
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [$clog2(REG_COUNT)-1:0] alu_reg,
  input  logic [REG_W-1:0]             alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [$clog2(REG_COUNT)-1:0] lsu_reg,
  input  logic [REG_W-1:0]             lsu_data,
  output logic                         wr_en,
  output logic [$clog2(REG_COUNT)-1:0] wr_reg,
  output logic [REG_W-1:0]             wr_data
);

  localparam int         REG_IDX_W  = $clog2(REG_COUNT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // One register-file write request: destination index plus data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [REG_W-1:0]     data;
  } wr_req_t;

  wr_req_t    alu_req, lsu_req, win_req;
  logic       force_alu;
  logic       alu_xfer, lsu_xfer, any_xfer;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       wr_en_q, wr_en_d;
  wr_req_t    wr_q, wr_d;

  assign alu_req = '{idx: alu_reg, data: alu_data};
  assign lsu_req = '{idx: lsu_reg, data: lsu_data};

  // Ready decode. It depends only on the valids and the starvation count, so
  // there is no combinational path from the wr_* outputs. The two readies
  // cannot both be taken in the same cycle.
  always_comb begin
    force_alu = (starve_cnt_q == STARVE_MAX);
    lsu_ready = !(alu_valid && force_alu);
    alu_ready = !lsu_valid || force_alu;
    alu_xfer  = alu_valid && alu_ready;
    lsu_xfer  = lsu_valid && lsu_ready;
    any_xfer  = alu_xfer || lsu_xfer;
  end

  // Starvation count. Clear it when the ALU wins or stops asking. Otherwise
  // count each lost cycle, and saturate at the limit so force stays high
  // until the ALU is served.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || alu_xfer)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // Select the winner and build the next write-port state. An x0 destination
  // still updates wr_reg/wr_data but never raises wr_en. Idle cycles hold
  // wr_reg/wr_data.
  always_comb begin
    win_req = lsu_xfer ? lsu_req : alu_req;
    wr_d    = wr_q;
    wr_en_d = 1'b0;
    if (any_xfer) begin
      wr_d    = win_req;
      wr_en_d = (win_req.idx != '0);
    end
  end

  // State registers. An asynchronous reset discards any write that was
  // accepted but not yet performed.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_q         <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_q.idx;
  assign wr_data = wr_q.data;

endmodule
